// File: rtl/alu_issue_unit.sv
// alu_issue_unit: queues ALU ops in a FIFO, issues them to an external combinational ALU and captures results on a valid/ready port
// Ports: clk/rst_n (async active-low); in_* op push port (valid/ready, use_acc selects acc as A);
//        alu_a/alu_b/alu_sel registered ALU inputs, alu_result/alu_carry ALU outputs;
//        out_* captured result port (valid/ready); acc = last captured result; fifo_count = queue occupancy.
module alu_issue_unit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_sel,
  input  logic                     in_use_acc,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [WIDTH-1:0]         acc,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + 4;
  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, head_use_acc;
  logic [WIDTH-1:0] head_a, head_b;
  logic [2:0] head_sel;
  assign in_ready = fifo_count != CW'(DEPTH);
  assign push = in_valid && in_ready;
  assign {head_use_acc, head_a, head_b, head_sel} = mem[rd_ptr];
  always_comb begin
    pop = fifo_count != '0 && (state == IDLE || (state == WAIT && out_ready));
    state_nxt = pop ? EXEC
              : state == EXEC ? WAIT
              : (state == WAIT && out_ready) ? IDLE
              : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_use_acc, in_a, in_b, in_sel};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      out_valid <= 1'b0;
      out_result <= '0;
      out_carry <= 1'b0;
      out_zero <= 1'b0;
      acc <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      // acc is captured in EXEC, always before the next pop, so chained ops see the fresh value
      if (pop) begin
        alu_a <= head_use_acc ? acc : head_a;
        alu_b <= head_b;
        alu_sel <= head_sel;
      end
      if (state == EXEC) begin
        out_valid <= 1'b1;
        out_result <= alu_result;
        out_carry <= alu_carry;
        out_zero <= alu_result == '0;
        acc <= alu_result;
      end else if (state == WAIT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed checks of the issue unit against a small behavioural ALU stub
module tb_alu_issue_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_use_acc, alu_carry, out_valid, out_ready, out_carry, out_zero;
  logic [3:0] in_a, in_b, alu_a, alu_b, alu_result, out_result, acc;
  logic [2:0] in_sel, alu_sel;
  logic [2:0] fifo_count;
  int n_cmp = 0;
  int n_err = 0;
  alu_issue_unit #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sel(in_sel), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .acc(acc), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  // ALU stub: 000 add with carry, 011 or, anything else xor
  assign {alu_carry, alu_result} = alu_sel == 3'b000 ? {1'b0, alu_a} + {1'b0, alu_b}
                                 : alu_sel == 3'b011 ? {1'b0, alu_a | alu_b}
                                 : {1'b0, alu_a ^ alu_b};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] s, input logic u);
    in_valid = v; in_a = a; in_b = b; in_sel = s; in_use_acc = u;
  endtask
  initial begin
    logic [3:0] exp_q [5];
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_acc", acc, 0);
    check("rst_out_result", out_result, 0);
    rst_n = 1'b1;
    step();
    // single add, latency 2
    out_ready = 1'b1;
    drive(1'b1, 4'd5, 4'd3, 3'b000, 1'b0);
    step();
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_valid_n1", out_valid, 0);
    step();
    check("t1_valid_n2", out_valid, 0);
    check("t1_alu_a", alu_a, 5);
    check("t1_alu_b", alu_b, 3);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 8);
    check("t1_carry", out_carry, 0);
    check("t1_zero", out_zero, 0);
    check("t1_acc", acc, 8);
    step();
    check("t1_consumed", out_valid, 0);
    // chained ops through the accumulator
    drive(1'b1, 4'd9, 4'd9, 3'b000, 1'b0);
    step();
    drive(1'b1, 4'd0, 4'd14, 3'b000, 1'b1);
    step();
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    step();
    check("t2_r1_valid", out_valid, 1);
    check("t2_r1_result", out_result, 2);
    check("t2_r1_carry", out_carry, 1);
    check("t2_r1_zero", out_zero, 0);
    step();
    check("t2_alu_a_from_acc", alu_a, 2);
    check("t2_gap_valid", out_valid, 0);
    step();
    check("t2_r2_valid", out_valid, 1);
    check("t2_r2_result", out_result, 0);
    check("t2_r2_carry", out_carry, 1);
    check("t2_r2_zero", out_zero, 1);
    check("t2_acc", acc, 0);
    step();
    check("t2_idle", out_valid, 0);
    // fill: 6 back-to-back pushes with out_ready low, 5 accepted
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 4'(k), 4'd1, 3'b000, 1'b0);
      step();
      check("t3_in_ready", in_ready, k < 5 ? 1 : 0);
    end
    check("t3_count_full", fifo_count, 4);
    check("t3_valid", out_valid, 1);
    check("t3_first_result", out_result, 2);
    // backpressure: outputs stay frozen while the unit keeps presenting op1
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_result", out_result, 2);
      check("t4_hold_carry", out_carry, 0);
      check("t4_hold_zero", out_zero, 0);
      check("t4_hold_acc", acc, 2);
      check("t4_hold_count", fifo_count, 4);
    end
    // full FIFO, in_valid high and a pop on the same edge: no write
    out_ready = 1'b1;
    drive(1'b1, 4'd7, 4'd1, 3'b000, 1'b0);
    step();
    check("t5_count_after_pop", fifo_count, 3);
    check("t5_in_ready", in_ready, 1);
    check("t4_consumed_once", out_valid, 0);
    exp_q = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) begin
        check("t5_push_next", fifo_count, 4);
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      end
      check("t3_drain_valid", out_valid, 1);
      check("t3_drain_result", out_result, exp_q[j]);
      step();
      check("t3_drain_gap", out_valid, 0);
    end
    check("t3_drained_count", fifo_count, 0);
    // reset mid-EXEC with 3 ops queued
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'(k), 4'd2, 3'b011, 1'b0);
      step();
    end
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    out_ready = 1'b1;
    check("t6_pre_result", out_result, 3);
    step();
    check("t6_pre_count", fifo_count, 3);
    check("t6_pre_alu_a", alu_a, 2);
    check("t6_pre_alu_sel", alu_sel, 3);
    check("t6_pre_acc", acc, 3);
    rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_count", fifo_count, 0);
    check("t6_acc", acc, 0);
    check("t6_alu_a", alu_a, 0);
    check("t6_alu_b", alu_b, 0);
    check("t6_alu_sel", alu_sel, 0);
    check("t6_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t6_no_stale_valid", out_valid, 0);
      check("t6_no_stale_count", fifo_count, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
